// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches and decodes program words, runs HALT/NOP/REPEAT locally
// and hands datapath opcodes to the NU array over a valid/ready + done handshake.
module inst_sequencer #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 6,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDR_W-1:0]        inst_addr,
    input  logic [INST_W-1:0]        inst_data,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [OP_W-1:0]          op_type,
    output logic [INST_W-OP_W-1:0]   op_args,
    input  logic                     op_done,
    output logic                     busy,
    output logic                     halted,
    output logic                     error
);
    localparam int ARG_HI = INST_W - OP_W - 1;

    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_REPEAT = OP_W'(2);
    localparam logic [OP_W-1:0] OP_FIRST  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LAST   = OP_W'(10);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, HALTED} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  loop_addr;
    logic               loop_active;
    logic [CNT_W-1:0]   loop_cnt;

    logic [OP_W-1:0]    opcode;
    logic [ADDR_W-1:0]  rep_tgt;
    logic [CNT_W-1:0]   rep_n;

    assign opcode    = inst_data[INST_W-1 -: OP_W];
    assign rep_tgt   = inst_data[ARG_HI -: ADDR_W];
    assign rep_n     = inst_data[ARG_HI-ADDR_W -: CNT_W];
    assign inst_addr = pc;
    assign busy      = (state != IDLE) && (state != HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            loop_addr   <= '0;
            loop_active <= 1'b0;
            loop_cnt    <= '0;
            op_valid    <= 1'b0;
            op_type     <= '0;
            op_args     <= '0;
            halted      <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state       <= FETCH;
                        pc          <= '0;
                        halted      <= 1'b0;
                        error       <= 1'b0;
                        loop_active <= 1'b0;
                        loop_cnt    <= '0;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALTED;
                    end else if (opcode == OP_NOP) begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end else if (opcode == OP_REPEAT) begin
                        state <= FETCH;
                        // Only the REPEAT that armed the loop may service it; any other is nesting.
                        if (loop_active && pc != loop_addr) begin
                            halted <= 1'b1;
                            error  <= 1'b1;
                            state  <= HALTED;
                        end else if (!loop_active) begin
                            if (rep_n == '0) begin
                                pc <= pc + 1'b1;
                            end else begin
                                loop_cnt    <= rep_n;
                                loop_active <= 1'b1;
                                loop_addr   <= pc;
                                pc          <= rep_tgt;
                            end
                        end else if (loop_cnt > CNT_W'(1)) begin
                            loop_cnt <= loop_cnt - 1'b1;
                            pc       <= rep_tgt;
                        end else begin
                            loop_cnt    <= '0;
                            loop_active <= 1'b0;
                            pc          <= pc + 1'b1;
                        end
                    end else if (opcode >= OP_FIRST && opcode <= OP_LAST) begin
                        op_type  <= opcode;
                        op_args  <= inst_data[ARG_HI:0];
                        op_valid <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        halted <= 1'b1;
                        error  <= 1'b1;
                        state  <= HALTED;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (op_done) begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: cycle-exact hand sequences plus a table of
// small programs run against a behavioural instruction memory and datapath responder.
module tb_inst_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  inst_addr;
    logic [31:0] inst_data;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [3:0]  op_type;
    logic [27:0] op_args;
    logic        op_done = 1'b0;
    logic        busy, halted, error;

    logic [31:0] mem [64];
    int n_chk = 0;
    int n_fail = 0;

    inst_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .inst_addr(inst_addr), .inst_data(inst_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type), .op_args(op_args),
        .op_done(op_done), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data one cycle after the address.
    always @(posedge clk) inst_data <= mem[inst_addr];

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          iss;
        logic [3:0]  t;
        logic [27:0] a;
        logic        err;
        logic [5:0]  addr;
        logic        loop;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] rep(input logic [5:0] t, input logic [9:0] n);
        return {4'd2, t, n, 12'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem(input logic [31:0] w);
        for (int i = 0; i < 64; i++) mem[i] = w;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Starts the program and acts as the datapath: always ready, done 3 cycles after accept.
    task automatic run_prog(input int budget, output int n_iss, output logic [3:0] t0,
                            output logic [27:0] a0, output bit to);
        int tmr;
        tmr = -1; n_iss = 0; t0 = '0; a0 = '0; to = 1'b1;
        op_ready = 1'b1;
        pulse_start();
        chk("restart_error", error, 0);
        chk("restart_halted", halted, 0);
        chk("restart_addr", inst_addr, 0);
        for (int c = 0; c < budget && to; c++) begin
            if (halted) begin
                to = 1'b0;
            end else begin
                op_done = 1'b0;
                if (tmr == 0) begin op_done = 1'b1; tmr = -1; end
                else if (tmr > 0) tmr--;
                if (op_valid && op_ready) begin
                    n_iss++;
                    if (n_iss == 1) begin t0 = op_type; a0 = op_args; end
                    tmr = 2;
                end
                @(negedge clk);
            end
        end
        op_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int iss; logic [3:0] t0; logic [27:0] a0; bit to;

        vecs[0]  = '{32'h3000_0123, 32'h0, 1, 4'd3,  28'h0000123, 1'b0, 6'd1, 1'b0};
        vecs[1]  = '{32'hAFFF_FFFF, 32'h0, 1, 4'd10, 28'hFFFFFFF, 1'b0, 6'd1, 1'b0};
        vecs[2]  = '{32'h0000_0000, 32'h0, 0, 4'd0,  28'h0,       1'b0, 6'd0, 1'b0};
        vecs[3]  = '{32'h1000_0000, 32'h0, 0, 4'd0,  28'h0,       1'b0, 6'd1, 1'b0};
        vecs[4]  = '{32'hC000_0000, 32'h0, 0, 4'd0,  28'h0,       1'b1, 6'd0, 1'b0};
        vecs[5]  = '{32'hB000_0000, 32'h0, 0, 4'd0,  28'h0,       1'b1, 6'd0, 1'b0};
        vecs[6]  = '{32'hF123_4567, 32'h0, 0, 4'd0,  28'h0,       1'b1, 6'd0, 1'b0};
        vecs[7]  = '{rep(6'd5, 10'd0), 32'h0, 0, 4'd0, 28'h0,     1'b0, 6'd1, 1'b0};
        vecs[8]  = '{32'h4000_0055, rep(6'd0, 10'd2), 3, 4'd4, 28'h55, 1'b0, 6'd2, 1'b0};
        vecs[9]  = '{rep(6'd1, 10'd1), rep(6'd0, 10'd1), 0, 4'd0, 28'h0, 1'b1, 6'd1, 1'b1};
        vecs[10] = '{rep(6'd2, 10'd1), 32'h0, 0, 4'd0, 28'h0,     1'b0, 6'd2, 1'b1};
        vecs[11] = '{rep(6'd0, 10'd1), 32'h0, 0, 4'd0, 28'h0,     1'b0, 6'd1, 1'b0};

        clear_mem(32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", op_valid, 0);
        chk("rst_type", op_type, 0);
        chk("rst_args", op_args, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", inst_addr, 0);

        // Cycle-exact single MATMUL then HALT.
        mem[0] = 32'h3000_0123;
        op_ready = 1'b1;
        pulse_start();                                   // now cycle 1
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_valid", op_valid, 0);
        @(negedge clk); chk("t1_c2_valid", op_valid, 0);
        @(negedge clk);
        chk("t1_c3_valid", op_valid, 1);
        chk("t1_c3_type", op_type, 3);
        chk("t1_c3_args", op_args, 28'h123);
        @(negedge clk); chk("t1_c4_valid", op_valid, 0);
        @(negedge clk);
        @(negedge clk); op_done = 1'b1;                  // cycle 6
        @(negedge clk); op_done = 1'b0;
        @(negedge clk); chk("t1_c8_halted", halted, 0);
        @(negedge clk);
        chk("t1_c9_halted", halted, 1);
        chk("t1_c9_busy", busy, 0);
        chk("t1_c9_addr", inst_addr, 1);

        // Backpressure: op_ready low for 5 cycles in ISSUE.
        mem[0] = 32'h7ABC_DEF1;
        op_ready = 1'b0;
        pulse_start();
        repeat (2) @(negedge clk);                       // cycle 3
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_hold%0d_valid", i), op_valid, 1);
            chk($sformatf("t2_hold%0d_type", i), op_type, 7);
            chk($sformatf("t2_hold%0d_args", i), op_args, 28'hABCDEF1);
            @(negedge clk);
        end
        op_ready = 1'b1;
        @(negedge clk); chk("t2_after_accept", op_valid, 0);
        @(negedge clk); chk("t2_single_xfer", op_valid, 0);
        op_done = 1'b1;
        @(negedge clk); op_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_halted", halted, 1);
        chk("t2_addr", inst_addr, 1);

        // start while busy is ignored.
        clear_mem(32'h0);
        mem[0] = 32'h1000_0000; mem[1] = 32'h1000_0000; mem[2] = 32'h3000_0077;
        op_ready = 1'b0;
        pulse_start();
        repeat (6) @(negedge clk);                       // cycle 7: ISSUE
        chk("t6_issue_valid", op_valid, 1);
        chk("t6_issue_addr", inst_addr, 2);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t6_ign_valid", op_valid, 1);
        chk("t6_ign_addr", inst_addr, 2);
        chk("t6_ign_args", op_args, 28'h77);
        op_ready = 1'b1;
        @(negedge clk); chk("t6_accept", op_valid, 0);
        op_done = 1'b1;
        @(negedge clk); op_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_halted", halted, 1);
        chk("t6_addr", inst_addr, 3);

        // Program table; each run restarts from the previous HALTED state.
        foreach (vecs[k]) begin
            clear_mem(32'h0);
            mem[0] = vecs[k].w0;
            mem[1] = vecs[k].w1;
            run_prog(200, iss, t0, a0, to);
            chk($sformatf("v%0d_timeout", k), to, 0);
            chk($sformatf("v%0d_issues", k), iss, vecs[k].iss);
            if (vecs[k].iss > 0) begin
                chk($sformatf("v%0d_type", k), t0, vecs[k].t);
                chk($sformatf("v%0d_args", k), a0, vecs[k].a);
            end
            chk($sformatf("v%0d_halted", k), halted, 1);
            chk($sformatf("v%0d_error", k), error, vecs[k].err);
            chk($sformatf("v%0d_addr", k), inst_addr, vecs[k].addr);
            chk($sformatf("v%0d_loop", k), dut.loop_active, vecs[k].loop);
        end

        // 64 NOPs: pc wraps 63 -> 0 and fetching continues.
        clear_mem(32'h1000_0000);
        pulse_start();                                   // cycle 1, FETCH pc 0
        repeat (126) @(negedge clk);
        chk("t5_addr63", inst_addr, 63);
        repeat (2) @(negedge clk);
        chk("t5_wrap0", inst_addr, 0);
        chk("t5_busy", busy, 1);
        repeat (2) @(negedge clk);
        chk("t5_wrap1", inst_addr, 1);

        // Reset mid-run, then reset while waiting for op_done.
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_addr", inst_addr, 0);
        mem[0] = 32'h5000_0042;
        op_ready = 1'b1;
        pulse_start();
        repeat (4) @(negedge clk);                       // cycle 5: WAIT
        chk("t5_wait_busy", busy, 1);
        chk("t5_wait_type", op_type, 5);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        op_done = 1'b1;
        chk("t5_wrst_valid", op_valid, 0);
        chk("t5_wrst_type", op_type, 0);
        chk("t5_wrst_args", op_args, 0);
        chk("t5_wrst_busy", busy, 0);
        chk("t5_wrst_halted", halted, 0);
        chk("t5_wrst_error", error, 0);
        @(negedge clk); op_done = 1'b0;
        chk("t5_stale_done_busy", busy, 0);
        chk("t5_stale_done_addr", inst_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
